mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Sequences the single RAM port of the SPARC datapath between two requesters: instruction fetch (IF) and load/store data (D). It owns the MFA/MFC memory handshake and latches the address, write data and operation for each access. It returns read data with a one-cycle done pulse, enforces alignment and a response timeout, and prevents fetch starvation. It sits between the CU/datapath request logic and the RAM.

Parameters:
STARVE_LIMIT, 4, consecutive D grants allowed while IF is pending before IF is forced ahead
TIMEOUT, 64, cycles MFA may stay high without MFC before the access is aborted
CNT_W, 7, width of the timeout counter; must hold TIMEOUT

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request; held high until if_done
if_addr  input  32  fetch address (word)
if_done  output  1  one-cycle completion pulse for fetch
if_err  output  1  valid with if_done; 1 = misaligned or timeout
if_rdata  output  32  fetched word; held until next IF completion
d_req  input  1  data request; held high until d_done
d_we  input  1  1 = store, 0 = load
d_size  input  2  00 byte, 01 halfword, 10 word
d_addr  input  32  data address
d_wdata  input  32  store data
d_done  output  1  one-cycle completion pulse for data
d_err  output  1  valid with d_done; 1 = misaligned or timeout
d_rdata  output  32  load data; held until next D completion
MFA  output  1  memory function active, to RAM
MOP  output  1  1 = write, 0 = read
MSIZE  output  2  access size to RAM
MADDR  output  32  latched address
MWDATA  output  32  latched write data
MRDATA  input  32  RAM read data, valid when MFC = 1
MFC  input  1  memory function complete

Behaviour:
- Reset value (Clk edge with Reset = 1): state IDLE. MFA, MOP, MSIZE, MADDR, MWDATA, both done/err outputs, both rdata outputs, starvation counter and timeout counter are all 0. Reset mid-access aborts the access immediately with no done pulse.
- States: IDLE, ACCESS, WAIT_LOW.
- IDLE arbitration, priority order:
  - D wins if d_req = 1, unless if_req = 1 and starve_cnt = STARVE_LIMIT.
  - Otherwise IF wins if if_req = 1.
- Misalignment check: halfword with d_addr[0] = 1; word with d_addr[1:0] != 0; fetch with if_addr[1:0] != 0.
  - A misaligned winner gets done = 1 and err = 1 on the next cycle.
  - No MFA is raised, the state stays IDLE, and starve_cnt is unchanged.
- Aligned grant: latch MADDR, MWDATA, MOP and MSIZE (fetch forces MOP = 0, MSIZE = 10). MFA = 1 on the next cycle; enter ACCESS with tcnt = 0.
- starve_cnt:
  - increments (saturating at STARVE_LIMIT) on each D grant while if_req = 1;
  - clears on any IF grant, and on any D grant while if_req = 0.
- ACCESS:
  - tcnt increments each cycle.
  - MFC = 1: capture MRDATA into the granted requester's rdata (loads/fetches only; stores leave d_rdata unchanged). Next cycle: MFA = 0, done = 1, err = 0; go to WAIT_LOW.
  - tcnt = TIMEOUT-1 with MFC = 0: next cycle MFA = 0, done = 1, err = 1, rdata unchanged; go to WAIT_LOW.
- WAIT_LOW: stay until MFC = 0, then go to IDLE. No new request is sampled here. A requester may keep or re-raise req during this state; it is evaluated in IDLE.
- Latency: request in IDLE at cycle 0 → MFA at cycle 1. MFC first high at cycle k → done and rdata valid at cycle k+1. Minimum back-to-back access spacing is 3 cycles when MFC drops immediately.
- MADDR, MWDATA, MOP and MSIZE are stable for the entire time MFA = 1.
- done pulses are exactly one cycle. if_done and d_done are never high in the same cycle.
- An MFC that is high while in IDLE is ignored.

Test Plan:
- Single fetch: if_req, if_addr = 0x40; RAM raises MFC 3 cycles after MFA with MRDATA = 0x9C044012 → if_done one cycle after MFC, if_rdata = 0x9C044012, MOP = 0, MSIZE = 10.
- Simultaneous requests: if_req and d_req (load, word, 0x80) in the same cycle → D served first; IF served in the next IDLE; MADDR = 0x80 then fetch address.
- Starvation: d_req held continuously with if_req high, STARVE_LIMIT = 4 → exactly 4 D accesses, then the IF access, then D resumes; starve_cnt back to 0.
- Misaligned: store halfword at 0x101 → d_done = 1, d_err = 1 on the next cycle, MFA never asserted; word load at 0x102 behaves the same.
- Timeout: MFC held 0 → MFA drops and d_done with d_err = 1 after TIMEOUT cycles (64); d_rdata unchanged from the previous load.
- Reset mid-access: Reset = 1 while in ACCESS → next cycle MFA = 0, all outputs 0, no done pulse; a fresh request after Reset = 0 completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between instruction fetch (IF) and load/store data (D).
// Ports:
//   clk_i, reset_i                 clock (rising edge) and synchronous active-high reset
//   if_req_i, if_addr_i            fetch request (held until if_done_o) and word address
//   if_done_o, if_err_o, if_rdata_o fetch completion pulse, error flag, fetched word
//   d_req_i, d_we_i, d_size_i      data request (held until d_done_o), store flag, size
//   d_addr_i, d_wdata_i            data address and store data
//   d_done_o, d_err_o, d_rdata_o   data completion pulse, error flag, load data
//   mfa_o, mop_o, msize_o          RAM strobe, write flag, access size
//   maddr_o, mwdata_o              latched RAM address and write data
//   mrdata_i, mfc_i                RAM read data and completion handshake
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64,
    parameter int CNT_W        = 7
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_done_o,
    output logic        if_err_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [1:0]  d_size_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_done_o,
    output logic        d_err_o,
    output logic [31:0] d_rdata_o,
    output logic        mfa_o,
    output logic        mop_o,
    output logic [1:0]  msize_o,
    output logic [31:0] maddr_o,
    output logic [31:0] mwdata_o,
    input  logic [31:0] mrdata_i,
    input  logic        mfc_i
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] S_MAX = SW'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT_LOW} state_t;

    state_t      state_q, state_d;
    logic        mfa_q, mfa_d;
    logic        mop_q, mop_d;
    logic [1:0]  msize_q, msize_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] mwdata_q, mwdata_d;
    logic        if_done_q, if_done_d;
    logic        if_err_q, if_err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        d_done_q, d_done_d;
    logic        d_err_q, d_err_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic        gnt_d_q, gnt_d_d;

    logic d_mis, if_mis, arb_ok, d_win, if_win;

    assign d_mis  = (d_size_i == 2'b01 && d_addr_i[0]) || (d_size_i[1] && d_addr_i[1:0] != 2'b00);
    assign if_mis = if_addr_i[1:0] != 2'b00;
    // A requester still holds req during the cycle its done pulse is visible,
    // so arbitration is suppressed then to avoid serving it twice.
    assign arb_ok = !(if_done_q || d_done_q);
    assign d_win  = arb_ok && d_req_i && !(if_req_i && starve_q == S_MAX);
    assign if_win = arb_ok && !d_win && if_req_i;

    always_comb begin
        state_d    = state_q;
        mfa_d      = mfa_q;
        mop_d      = mop_q;
        msize_d    = msize_q;
        maddr_d    = maddr_q;
        mwdata_d   = mwdata_q;
        if_done_d  = 1'b0;
        if_err_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        d_done_d   = 1'b0;
        d_err_d    = 1'b0;
        d_rdata_d  = d_rdata_q;
        starve_d   = starve_q;
        tcnt_d     = tcnt_q;
        gnt_d_d    = gnt_d_q;
        case (state_q)
            IDLE: begin
                if (d_win && d_mis) begin
                    d_done_d = 1'b1;
                    d_err_d  = 1'b1;
                end else if (d_win) begin
                    gnt_d_d  = 1'b1;
                    maddr_d  = d_addr_i;
                    mwdata_d = d_wdata_i;
                    mop_d    = d_we_i;
                    msize_d  = d_size_i;
                    mfa_d    = 1'b1;
                    tcnt_d   = '0;
                    state_d  = ACCESS;
                    starve_d = !if_req_i ? '0 : (starve_q == S_MAX ? starve_q : starve_q + 1'b1);
                end else if (if_win && if_mis) begin
                    if_done_d = 1'b1;
                    if_err_d  = 1'b1;
                end else if (if_win) begin
                    gnt_d_d  = 1'b0;
                    maddr_d  = if_addr_i;
                    mop_d    = 1'b0;
                    msize_d  = 2'b10;
                    mfa_d    = 1'b1;
                    tcnt_d   = '0;
                    state_d  = ACCESS;
                    starve_d = '0;
                end
            end
            ACCESS: begin
                tcnt_d = tcnt_q + 1'b1;
                if (mfc_i || tcnt_q == T_LAST) begin
                    mfa_d     = 1'b0;
                    state_d   = WAIT_LOW;
                    d_done_d  = gnt_d_q;
                    if_done_d = !gnt_d_q;
                    d_err_d   = gnt_d_q && !mfc_i;
                    if_err_d  = !gnt_d_q && !mfc_i;
                    if (mfc_i && !gnt_d_q)
                        if_rdata_d = mrdata_i;
                    if (mfc_i && gnt_d_q && !mop_q)
                        d_rdata_d = mrdata_i;
                end
            end
            WAIT_LOW: begin
                if (!mfc_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            mfa_q      <= 1'b0;
            mop_q      <= 1'b0;
            msize_q    <= 2'b00;
            maddr_q    <= '0;
            mwdata_q   <= '0;
            if_done_q  <= 1'b0;
            if_err_q   <= 1'b0;
            if_rdata_q <= '0;
            d_done_q   <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= '0;
            starve_q   <= '0;
            tcnt_q     <= '0;
            gnt_d_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mfa_q      <= mfa_d;
            mop_q      <= mop_d;
            msize_q    <= msize_d;
            maddr_q    <= maddr_d;
            mwdata_q   <= mwdata_d;
            if_done_q  <= if_done_d;
            if_err_q   <= if_err_d;
            if_rdata_q <= if_rdata_d;
            d_done_q   <= d_done_d;
            d_err_q    <= d_err_d;
            d_rdata_q  <= d_rdata_d;
            starve_q   <= starve_d;
            tcnt_q     <= tcnt_d;
            gnt_d_q    <= gnt_d_d;
        end
    end

    assign mfa_o      = mfa_q;
    assign mop_o      = mop_q;
    assign msize_o    = msize_q;
    assign maddr_o    = maddr_q;
    assign mwdata_o   = mwdata_q;
    assign if_done_o  = if_done_q;
    assign if_err_o   = if_err_q;
    assign if_rdata_o = if_rdata_q;
    assign d_done_o   = d_done_q;
    assign d_err_o    = d_err_q;
    assign d_rdata_o  = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter with a behavioural RAM.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_done, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_done, d_err;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        mfa, mop, mfc;
    logic [1:0]  msize;
    logic [31:0] maddr, mwdata, mrdata;

    typedef struct packed {logic is_d; logic err; logic [31:0] rdata;} exp_t;
    typedef struct packed {logic [31:0] addr; logic [31:0] wdata; logic mop; logic [1:0] msize;} acc_t;
    exp_t sb[$];
    acc_t log_q[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0, mfc_cyc = 0, mfa_cycles = 0, lat = 3;
    bit hang = 0;
    logic [31:0] last_if = '0, last_d = '0;

    mem_port_arbiter dut (
        .clk_i(clk), .reset_i(reset),
        .if_req_i(if_req), .if_addr_i(if_addr),
        .if_done_o(if_done), .if_err_o(if_err), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_size_i(d_size), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_done_o(d_done), .d_err_o(d_err), .d_rdata_o(d_rdata),
        .mfa_o(mfa), .mop_o(mop), .msize_o(msize), .maddr_o(maddr), .mwdata_o(mwdata),
        .mrdata_i(mrdata), .mfc_i(mfc)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a == 32'h40 ? 32'h9C044012 : {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RAM: raises MFC lat cycles after first seeing MFA, holds it until MFA drops.
    initial begin
        bit active = 0;
        int cnt = 0;
        mfc = 1'b0;
        mrdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!mfa) begin
                mfc = 1'b0; cnt = 0; active = 0;
            end else begin
                if (!active) begin
                    log_q.push_back('{maddr, mwdata, mop, msize});
                    mfa_cycles = 0;
                    active = 1;
                end
                mfa_cycles++;
                if (!mfc && !hang) begin
                    if (cnt == lat) begin
                        mfc = 1'b1; mrdata = data_of(maddr); mfc_cyc = cyc;
                    end else cnt++;
                end
            end
        end
    end

    // Completion monitor: pops the scoreboard on every done pulse.
    initial forever begin
        @(negedge clk);
        if (!reset && (if_done || d_done)) begin
            exp_t e;
            chk("one_done", 32'(if_done & d_done), 32'd0);
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("done_port", 32'(d_done), 32'(e.is_d));
                chk("err", 32'(e.is_d ? d_err : if_err), 32'(e.err));
                chk("rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
                if (!e.err) chk("latency", cyc, mfc_cyc + 1);
            end
        end
    end

    task automatic wait_done(input bit want_d, input string tag);
        int k = 0;
        do begin @(posedge clk); #1; k++; end
        while (!(want_d ? d_done : if_done) && k < 200);
        chk({tag, "_seen"}, 32'(want_d ? d_done : if_done), 32'd1);
    endtask

    task automatic push_d(input logic we, input logic [1:0] sz, input logic [31:0] a);
        logic mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
        logic e = mis || hang;
        logic [31:0] r = (e || we) ? last_d : data_of(a);
        last_d = r;
        sb.push_back('{1'b1, e, r});
    endtask

    task automatic push_if(input logic [31:0] a);
        logic e = a[1:0] != 2'b00 || hang;
        logic [31:0] r = e ? last_if : data_of(a);
        last_if = r;
        sb.push_back('{1'b0, e, r});
    endtask

    task automatic do_d(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd, input string tag);
        push_d(we, sz, a);
        d_we = we; d_size = sz; d_addr = a; d_wdata = wd; d_req = 1'b1;
        wait_done(1'b1, tag);
        d_req = 1'b0;
    endtask

    task automatic do_if(input logic [31:0] a, input string tag);
        push_if(a);
        if_addr = a; if_req = 1'b1;
        wait_done(1'b0, tag);
        if_req = 1'b0;
    endtask

    initial begin
        int base;
        reset = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_size = 2'b10; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mfa", 32'(mfa), 0); chk("rst_mop", 32'(mop), 0); chk("rst_msize", 32'(msize), 0);
        chk("rst_maddr", maddr, 0); chk("rst_mwdata", mwdata, 0);
        chk("rst_dones", 32'({if_done, d_done, if_err, d_err}), 0);
        chk("rst_if_rdata", if_rdata, 0); chk("rst_d_rdata", d_rdata, 0);
        chk("rst_starve", 32'(dut.starve_q), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // single fetch, MFC three cycles after MFA
        base = log_q.size();
        do_if(32'h40, "fetch40");
        chk("fetch_addr", log_q[base].addr, 32'h40);
        chk("fetch_mop", 32'(log_q[base].mop), 0);
        chk("fetch_msize", 32'(log_q[base].msize), 2);
        lat = 1;

        // load then store; store leaves d_rdata alone
        do_d(1'b0, 2'b10, 32'h80, 32'h0, "load80");
        base = log_q.size();
        do_d(1'b1, 2'b10, 32'h84, 32'h12345678, "store84");
        chk("store_mop", 32'(log_q[base].mop), 1);
        chk("store_wdata", log_q[base].wdata, 32'h12345678);

        // simultaneous requests: D first, then IF
        base = log_q.size();
        push_d(1'b0, 2'b10, 32'h80);
        push_if(32'h44);
        d_we = 0; d_size = 2'b10; d_addr = 32'h80; if_addr = 32'h44;
        d_req = 1; if_req = 1;
        wait_done(1'b1, "simul_d"); d_req = 0;
        wait_done(1'b0, "simul_if"); if_req = 0;
        chk("simul_first", log_q[base].addr, 32'h80);
        chk("simul_second", log_q[base + 1].addr, 32'h44);

        // starvation: four D grants, forced IF, then D resumes
        base = log_q.size();
        for (int i = 0; i < 4; i++) push_d(1'b0, 2'b10, 32'h100 + 32'(4 * i));
        push_if(32'h48);
        push_d(1'b0, 2'b10, 32'h110);
        begin
            int di = 0, nd = 0, k = 0;
            d_addr = 32'h100; if_addr = 32'h48; d_req = 1; if_req = 1;
            while (nd < 6 && k < 400) begin
                @(posedge clk); #1; k++;
                if (d_done) begin
                    nd++; di++;
                    if (di < 5) d_addr = 32'h100 + 32'(4 * di); else d_req = 0;
                end
                if (if_done) begin nd++; if_req = 0; end
            end
            chk("starve_all_done", nd, 6);
        end
        chk("starve_d0", log_q[base].addr, 32'h100);
        chk("starve_d3", log_q[base + 3].addr, 32'h10C);
        chk("starve_if", log_q[base + 4].addr, 32'h48);
        chk("starve_d4", log_q[base + 5].addr, 32'h110);
        chk("starve_cnt", 32'(dut.starve_q), 0);

        // misaligned requests never reach the RAM
        base = log_q.size();
        do_d(1'b1, 2'b01, 32'h101, 32'hAAAA, "mis_half");
        chk("mis_half_mfa", 32'(mfa), 0);
        do_d(1'b0, 2'b10, 32'h102, 32'h0, "mis_word");
        do_if(32'h42, "mis_fetch");
        do_d(1'b0, 2'b01, 32'h106, 32'h0, "half_ok");
        chk("mis_no_access", log_q.size(), base + 1);

        // timeout with no MFC
        hang = 1;
        do_d(1'b0, 2'b10, 32'h200, 32'h0, "timeout");
        chk("timeout_mfa_cycles", mfa_cycles, 64);
        chk("timeout_mfa_low", 32'(mfa), 0);
        hang = 0;
        @(posedge clk); #1;

        // reset mid-access
        lat = 10;
        d_we = 0; d_size = 2'b10; d_addr = 32'h300; d_req = 1;
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_rst_mfa", 32'(mfa), 1);
        reset = 1; d_req = 0;
        @(posedge clk); #1;
        chk("midrst_mfa", 32'(mfa), 0);
        chk("midrst_dones", 32'({if_done, d_done}), 0);
        chk("midrst_maddr", maddr, 0);
        chk("midrst_rdata", d_rdata | if_rdata, 0);
        last_d = '0; last_if = '0;
        reset = 0; lat = 2;
        @(posedge clk); #1;
        do_d(1'b0, 2'b10, 32'h304, 32'h0, "post_rst");

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
